// File: rtl/frame_decrypter_pkg.sv
// Shared definitions for the frame decrypter: mode encodings, the controller
// state type and the keystream step used by the LFSR decryption mode.
package frame_decrypter_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_XOR  = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One step of a right-shifting Galois LFSR. Operands are carried at 32 bits
    // so any word width up to 32 can share this helper; callers truncate.
    function automatic logic [31:0] lfsrStep(input logic [31:0] s, input logic [31:0] taps);
        lfsrStep = (s >> 1) ^ (s[0] ? taps : 32'd0);
    endfunction

endpackage

// File: rtl/decrypt_pipe.sv
// Read-latency delay line and write-side output register for the frame
// decrypter. Each issued address travels RD_LATENCY stages so it lines up with
// the RAM data it fetched; on exit the word is decrypted and registered.
module decrypt_pipe
    import frame_decrypter_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 15,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueAddr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] lfsr,
    output logic              exitValid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    logic [RD_LATENCY-1:0] valid_q;
    logic [ADDR_W-1:0]     addr_q [RD_LATENCY];
    logic [DATA_W-1:0]     plain;
    logic                  wrEn_q;
    logic [ADDR_W-1:0]     wrAddr_q;
    logic [DATA_W-1:0]     wrData_q;

    // Shift issued addresses and their valid flags along to match RAM latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= issueValid;
            addr_q[0]  <= issueAddr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    // Decrypt the word arriving from RAM; reserved mode falls back to pass-through.
    always_comb begin
        plain = rd_data;
        case (mode)
            MODE_XOR:  plain = rd_data ^ key ^ (key << 4);
            MODE_LFSR: plain = rd_data ^ lfsr;
            default:   plain = rd_data;
        endcase
    end

    assign exitValid = valid_q[RD_LATENCY-1];

    // Register the write; address and data hold their last value between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
        end else begin
            wrEn_q <= exitValid;
            if (exitValid) begin
                wrAddr_q <= addr_q[RD_LATENCY-1];
                wrData_q <= plain;
            end
        end
    end

    assign wr_en   = wrEn_q;
    assign wr_addr = wrAddr_q;
    assign wr_data = wrData_q;

endmodule

// File: rtl/frame_decrypter.sv
// Frame decrypter top: sweeps the encrypted frame RAM once per start, decrypts
// each word and writes it to the same address of the display buffer.
// Optional build macro FRAME_DECRYPTER_CHECKSUM_EN adds an XOR checksum output
// of all words written in the last frame.
module frame_decrypter
    import frame_decrypter_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 15,
    parameter int                NUM_PIXELS = 19200,
    parameter int                RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] KEY_RST    = DATA_W'(8'hB3),
    parameter logic [DATA_W-1:0] LFSR_TAPS  = DATA_W'(8'hB8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              key_load,
    input  logic [DATA_W-1:0] key_in,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic [DATA_W-1:0] seedKey;
    logic              exitValid;
    logic              lastWrite;
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

    // A key loaded in the same cycle as start must seed the keystream.
    assign seedKey   = key_load ? key_in : key_q;
    assign lastWrite = wr_en && (wr_addr == LAST_ADDR);
    assign rd_addr   = rdAddr_q;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one frame per accepted start, then back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (rdAddr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:   if (lastWrite) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = (state_q == RUN) || (state_q == DRAIN);
        done = (state_q == DONE);
    end

    // Datapath next values: key load, frame setup, address sweep, keystream.
    always_comb begin
        rdAddr_d = rdAddr_q;
        mode_d   = mode_q;
        key_d    = key_q;
        lfsr_d   = lfsr_q;
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
        checksum_d = checksum_q;
        if (wr_en) checksum_d = checksum_q ^ wr_data;
`endif
        if (exitValid) lfsr_d = DATA_W'(lfsrStep(32'(lfsr_q), 32'(LFSR_TAPS)));
        case (state_q)
            IDLE: begin
                if (key_load) key_d = key_in;
                if (start) begin
                    mode_d   = mode;
                    lfsr_d   = (seedKey == '0) ? DATA_W'(1) : seedKey;
                    rdAddr_d = '0;
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            RUN: begin
                if (rdAddr_q != LAST_ADDR) rdAddr_d = rdAddr_q + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdAddr_q <= '0;
            mode_q   <= MODE_PASS;
            key_q    <= KEY_RST;
            lfsr_q   <= '0;
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            rdAddr_q <= rdAddr_d;
            mode_q   <= mode_d;
            key_q    <= key_d;
            lfsr_q   <= lfsr_d;
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

`ifdef FRAME_DECRYPTER_CHECKSUM_EN
    assign checksum = checksum_q;
`endif

    decrypt_pipe #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RD_LATENCY(RD_LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .issueValid(state_q == RUN),
        .issueAddr (rdAddr_q),
        .rd_data   (rd_data),
        .mode      (mode_q),
        .key       (key_q),
        .lfsr      (lfsr_q),
        .exitValid (exitValid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

endmodule

// File: tb/tb_frame_decrypter.sv
// Bench for frame_decrypter: a small 1-cycle-latency instance (A) carries most
// scenarios, a 3-cycle-latency instance (B) checks delay alignment. Expected
// frames come from a word-level model of the decryption rules.
`timescale 1ns/1ps
module tb_frame_decrypter;

    localparam int NA = 4;
    localparam int LA = 1;
    localparam int NB = 6;
    localparam int LB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        startA, keyLoadA, wrEnA, busyA, doneA;
    logic [1:0]  modeA;
    logic [7:0]  keyInA, rdDataA, wrDataA;
    logic [14:0] rdAddrA, wrAddrA;
    logic        startB, keyLoadB, wrEnB, busyB, doneB;
    logic [1:0]  modeB;
    logic [7:0]  keyInB, rdDataB, wrDataB;
    logic [14:0] rdAddrB, wrAddrB;
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
    logic [7:0]  checksumA, checksumB;
`endif

    frame_decrypter #(
        .DATA_W(8), .ADDR_W(15), .NUM_PIXELS(NA), .RD_LATENCY(LA),
        .KEY_RST(8'hB3), .LFSR_TAPS(8'hB8)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .mode(modeA),
        .key_load(keyLoadA), .key_in(keyInA), .rd_addr(rdAddrA), .rd_data(rdDataA),
        .wr_en(wrEnA), .wr_addr(wrAddrA), .wr_data(wrDataA), .busy(busyA), .done(doneA)
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
        , .checksum(checksumA)
`endif
    );

    frame_decrypter #(
        .DATA_W(8), .ADDR_W(15), .NUM_PIXELS(NB), .RD_LATENCY(LB),
        .KEY_RST(8'hB3), .LFSR_TAPS(8'hB8)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .mode(modeB),
        .key_load(keyLoadB), .key_in(keyInB), .rd_addr(rdAddrB), .rd_data(rdDataB),
        .wr_en(wrEnB), .wr_addr(wrAddrB), .wr_data(wrDataB), .busy(busyB), .done(doneB)
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
        , .checksum(checksumB)
`endif
    );

    // Source RAM models: A answers one cycle after the address, B three.
    logic [7:0] ramA [0:7];
    logic [7:0] ramB [0:7];
    logic [7:0] pipeB [0:2];
    always @(posedge clk) rdDataA <= ramA[rdAddrA[2:0]];
    always @(posedge clk) begin
        pipeB[0] <= ramB[rdAddrB[2:0]];
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign rdDataB = pipeB[2];

    // Monitor, sampling 1ns after each rising edge.
    int          cyc = 0;
    logic [14:0] qAddrA[$], qAddrB[$];
    logic [7:0]  qDataA[$], qDataB[$];
    int          qCycA[$], qCycB[$];
    int          doneCntA, doneCycA, firstRdCycA, doneCntB, firstRdCycB;
    logic        busyAtDoneA;
    logic [14:0] rdHistB [0:8191];
    always @(posedge clk) begin
        #1;
        cyc++;
        rdHistB[cyc % 8192] = rdAddrB;
        if (wrEnA) begin qAddrA.push_back(wrAddrA); qDataA.push_back(wrDataA); qCycA.push_back(cyc); end
        if (doneA) begin doneCntA++; doneCycA = cyc; busyAtDoneA = busyA; end
        if (busyA && rdAddrA == 15'd0 && firstRdCycA < 0) firstRdCycA = cyc;
        if (wrEnB) begin qAddrB.push_back(wrAddrB); qDataB.push_back(wrDataB); qCycB.push_back(cyc); end
        if (doneB) doneCntB++;
        if (busyB && rdAddrB == 15'd0 && firstRdCycB < 0) firstRdCycB = cyc;
    end

    int         checks = 0;
    int         failures = 0;
    logic [7:0] modelKeyA = 8'hB3;
    logic [7:0] modelKeyB = 8'hB3;
    logic [7:0] expW [0:7];
    logic [7:0] expSum;

    // Word-level reference: decrypt n words of the chosen RAM with the given key.
    task automatic modelFrame(input int which, input logic [1:0] m, input logic [7:0] key, input int n);
        logic [7:0] s, d;
        s = (key == 8'h00) ? 8'h01 : key;
        expSum = 8'h00;
        for (int i = 0; i < n; i++) begin
            d = (which == 0) ? ramA[i] : ramB[i];
            case (m)
                2'd1: expW[i] = d ^ key ^ {key[3:0], 4'h0};
                2'd2: begin
                    expW[i] = d ^ s;
                    s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
                end
                default: expW[i] = d;
            endcase
            expSum ^= expW[i];
        end
    endtask

    task automatic clearMon();
        qAddrA.delete(); qDataA.delete(); qCycA.delete();
        qAddrB.delete(); qDataB.delete(); qCycB.delete();
        doneCntA = 0; doneCycA = -1; firstRdCycA = -1; busyAtDoneA = 1'b1;
        doneCntB = 0; firstRdCycB = -1;
    endtask

    task automatic runFrameA(input logic [1:0] m, input logic kl, input logic [7:0] ki, output bit timedOut);
        clearMon();
        @(negedge clk);
        startA = 1'b1; modeA = m; keyLoadA = kl; keyInA = ki;
        @(negedge clk);
        startA = 1'b0; keyLoadA = 1'b0; keyInA = 8'($urandom); modeA = 2'($urandom);
        if (kl) modelKeyA = ki;
        timedOut = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (doneCntA > 0) begin timedOut = 1'b0; break; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        startA = 0; modeA = 0; keyLoadA = 0; keyInA = 0;
        startB = 0; modeB = 0; keyLoadB = 0; keyInB = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (wrEnA !== 1'b0)     begin failures++; $display("[TB] FAIL reset_wr_en got=%b want=0", wrEnA); end
        checks++; if (busyA !== 1'b0)     begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busyA); end
        checks++; if (doneA !== 1'b0)     begin failures++; $display("[TB] FAIL reset_done got=%b want=0", doneA); end
        checks++; if (rdAddrA !== 15'd0)  begin failures++; $display("[TB] FAIL reset_rd_addr got=%0d want=0", rdAddrA); end
        checks++; if (wrAddrA !== 15'd0)  begin failures++; $display("[TB] FAIL reset_wr_addr got=%0d want=0", wrAddrA); end
        checks++; if (wrDataA !== 8'h00)  begin failures++; $display("[TB] FAIL reset_wr_data got=%h want=00", wrDataA); end
    endtask

    task automatic test_pass_timing();
        bit tmo;
        ramA[0] = 8'd10; ramA[1] = 8'd20; ramA[2] = 8'd30; ramA[3] = 8'd40;
        runFrameA(2'd0, 1'b0, 8'h00, tmo);
        checks++; if (tmo) begin failures++; $display("[TB] FAIL pass_timeout got=no_done want=done"); end
        checks++; if (qDataA.size() != NA) begin failures++; $display("[TB] FAIL pass_count got=%0d want=%0d", qDataA.size(), NA); end
        for (int i = 0; i < qDataA.size() && i < NA; i++) begin
            checks++;
            if (qAddrA[i] !== 15'(i) || qDataA[i] !== 8'(10 * (i + 1))) begin
                failures++; $display("[TB] FAIL pass_word%0d got=(%0d,%0d) want=(%0d,%0d)", i, qAddrA[i], qDataA[i], i, 10 * (i + 1));
            end
        end
        if (qCycA.size() == NA) begin
            checks++; if (qCycA[0] - firstRdCycA != LA + 1) begin failures++; $display("[TB] FAIL first_write_latency got=%0d want=%0d", qCycA[0] - firstRdCycA, LA + 1); end
            checks++; if (doneCycA - qCycA[NA-1] != 1) begin failures++; $display("[TB] FAIL done_after_last got=%0d want=1", doneCycA - qCycA[NA-1]); end
        end
        checks++; if (busyAtDoneA !== 1'b0) begin failures++; $display("[TB] FAIL busy_at_done got=%b want=0", busyAtDoneA); end
        checks++; if (doneCntA != 1) begin failures++; $display("[TB] FAIL done_pulses got=%0d want=1", doneCntA); end
    endtask

    task automatic test_xor_lfsr_fixed();
        bit tmo;
        ramA[0] = 8'h00; ramA[1] = 8'hFF; ramA[2] = 8'h00; ramA[3] = 8'h00;
        runFrameA(2'd1, 1'b0, 8'h00, tmo);
        checks++; if (tmo || qDataA.size() < 2 || qDataA[0] !== 8'h83 || qDataA[1] !== 8'h7C) begin
            failures++; $display("[TB] FAIL xor_fixed got=%0d_words want=83,7C", qDataA.size());
        end
        ramA[1] = 8'h00;
        runFrameA(2'd2, 1'b0, 8'h00, tmo);
        checks++; if (tmo || qDataA.size() < 3 || qDataA[0] !== 8'hB3 || qDataA[1] !== 8'hE1 || qDataA[2] !== 8'hC8) begin
            failures++; $display("[TB] FAIL lfsr_fixed got=%0d_words want=B3,E1,C8", qDataA.size());
        end
        runFrameA(2'd2, 1'b1, 8'h00, tmo);
        checks++; if (tmo || qDataA.size() < 1 || qDataA[0] !== 8'h01) begin
            failures++; $display("[TB] FAIL lfsr_zero_key got=%0d_words want_first=01", qDataA.size());
        end
    endtask

    task automatic test_random();
        bit         tmo;
        logic [1:0] m;
        logic       kl;
        logic [7:0] ki;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < NA; i++) ramA[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); keyLoadA = 1'b1; keyInA = 8'($urandom); modelKeyA = keyInA;
                @(negedge clk); keyLoadA = 1'b0;
            end
            m = 2'($urandom_range(0, 3)); kl = 1'($urandom); ki = 8'($urandom);
            runFrameA(m, kl, ki, tmo);
            modelFrame(0, m, modelKeyA, NA);
            checks++; if (tmo || qDataA.size() != NA) begin failures++; $display("[TB] FAIL rand%0d_count got=%0d want=%0d", f, qDataA.size(), NA); end
            for (int i = 0; i < qDataA.size() && i < NA; i++) begin
                checks++;
                if (qAddrA[i] !== 15'(i) || qDataA[i] !== expW[i]) begin
                    failures++; $display("[TB] FAIL rand%0d_word%0d mode=%0d got=(%0d,%h) want=(%0d,%h)", f, i, m, qAddrA[i], qDataA[i], i, expW[i]);
                end
            end
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
            checks++; if (checksumA !== expSum) begin failures++; $display("[TB] FAIL rand%0d_checksum got=%h want=%h", f, checksumA, expSum); end
`endif
        end
    endtask

    task automatic test_start_held();
        bit tmo;
        for (int i = 0; i < NA; i++) ramA[i] = 8'($urandom);
        clearMon();
        @(negedge clk); startA = 1'b1; modeA = 2'd1; keyLoadA = 1'b0;
        @(negedge clk); @(negedge clk);
        keyLoadA = 1'b1; keyInA = modelKeyA ^ 8'h5A;
        @(negedge clk); @(negedge clk); keyLoadA = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (doneCntA > 0) begin tmo = 1'b0; break; end
        end
        startA = 1'b0;
        repeat (10) @(negedge clk);
        modelFrame(0, 2'd1, modelKeyA, NA);
        checks++; if (tmo || qDataA.size() != NA || doneCntA != 1) begin
            failures++; $display("[TB] FAIL held_one_frame got=%0d_writes/%0d_done want=%0d/1", qDataA.size(), doneCntA, NA);
        end
        checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL held_idle_busy got=%b want=0", busyA); end
        for (int i = 0; i < qDataA.size() && i < NA; i++) begin
            checks++; if (qDataA[i] !== expW[i]) begin failures++; $display("[TB] FAIL held_word%0d got=%h want=%h", i, qDataA[i], expW[i]); end
        end
        runFrameA(2'd1, 1'b0, 8'h00, tmo);
        modelFrame(0, 2'd1, modelKeyA, NA);
        checks++; if (tmo || qDataA.size() != NA || qDataA[NA-1] !== expW[NA-1] || qDataA[0] !== expW[0]) begin
            failures++; $display("[TB] FAIL held_key_kept got=%0d_words want=%0d_with_key_%h", qDataA.size(), NA, modelKeyA);
        end
    endtask

    task automatic test_reset_mid();
        bit tmo;
        int seen;
        for (int i = 0; i < NA; i++) ramA[i] = 8'($urandom);
        clearMon();
        @(negedge clk); startA = 1'b1; modeA = 2'd2; keyLoadA = 1'b1; keyInA = 8'h5A;
        @(negedge clk); startA = 1'b0; keyLoadA = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (qDataA.size() >= 2) begin tmo = 1'b0; break; end
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (tmo || wrEnA !== 1'b0 || busyA !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_reset got=wr_en%b/busy%b want=0/0", wrEnA, busyA);
        end
        seen = qDataA.size();
        repeat (12) @(negedge clk);
        checks++; if (qDataA.size() != seen || doneCntA != 0) begin
            failures++; $display("[TB] FAIL mid_reset_quiet got=%0d_writes/%0d_done want=%0d/0", qDataA.size(), doneCntA, seen);
        end
        modelKeyA = 8'hB3;
        ramA[0] = 8'h00; ramA[1] = 8'hFF;
        runFrameA(2'd1, 1'b0, 8'h00, tmo);
        checks++; if (tmo || qDataA.size() < 2 || qDataA[0] !== 8'h83 || qDataA[1] !== 8'h7C) begin
            failures++; $display("[TB] FAIL mid_reset_key got=%0d_words want=83,7C", qDataA.size());
        end
    endtask

    task automatic test_latency_b();
        bit         tmo;
        logic [1:0] m;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NB; i++) ramB[i] = 8'($urandom);
            m = 2'($urandom_range(0, 2));
            clearMon();
            @(negedge clk); startB = 1'b1; modeB = m;
            @(negedge clk); startB = 1'b0;
            tmo = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (doneCntB > 0) begin tmo = 1'b0; break; end
            end
            repeat (3) @(negedge clk);
            modelFrame(1, m, modelKeyB, NB);
            checks++; if (tmo || qDataB.size() != NB) begin failures++; $display("[TB] FAIL lat3_count got=%0d want=%0d", qDataB.size(), NB); end
            for (int i = 0; i < qDataB.size() && i < NB; i++) begin
                checks++;
                if (qAddrB[i] !== 15'(i) || qDataB[i] !== expW[i] || qAddrB[i] !== rdHistB[(qCycB[i] - (LB + 1)) % 8192]) begin
                    failures++; $display("[TB] FAIL lat3_word%0d got=(%0d,%h) want=(%0d,%h)", i, qAddrB[i], qDataB[i], i, expW[i]);
                end
            end
            if (qCycB.size() > 0) begin
                checks++; if (qCycB[0] - firstRdCycB != LB + 1) begin failures++; $display("[TB] FAIL lat3_first got=%0d want=%0d", qCycB[0] - firstRdCycB, LB + 1); end
            end
        end
    endtask

`ifdef FRAME_DECRYPTER_CHECKSUM_EN
    task automatic test_checksum();
        bit tmo;
        ramA[0] = 8'h01; ramA[1] = 8'h02; ramA[2] = 8'h04; ramA[3] = 8'h00;
        runFrameA(2'd0, 1'b0, 8'h00, tmo);
        checks++; if (tmo || checksumA !== 8'h07) begin failures++; $display("[TB] FAIL checksum_fixed got=%h want=07", checksumA); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) begin ramA[i] = 8'h00; ramB[i] = 8'h00; end
        test_reset();
        test_pass_timing();
        test_xor_lfsr_fixed();
        test_random();
        test_start_held();
        test_reset_mid();
        test_latency_b();
`ifdef FRAME_DECRYPTER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
